// File: rtl/uart_mult_byte_tx.sv
// rtl/uart_mult_byte_tx.sv - 8-byte packet UART transmitter (0x55, A, B, C, CR, LF)
module uart_mult_byte_tx #(
    parameter int          CLK_FREQ = 50_000_000,
    parameter int          UART_BPS = 230400,
    parameter logic [7:0]  HEADER   = 8'h55
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        pack_start,
    input  logic [7:0]  dataA,
    input  logic [15:0] dataB,
    input  logic [15:0] dataC,
    output logic        pack_busy,
    output logic        pack_done,
    output logic [2:0]  byte_cnt,
    output logic        uart_txd
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int CW      = $clog2(BPS_CNT + 1);
    localparam logic [CW-1:0] BPS_LAST = CW'(BPS_CNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shadow_a;
    logic [15:0]   shadow_b;
    logic [15:0]   shadow_c;
    logic [7:0]    cur_byte;
    logic          baud_end;

    assign baud_end = (baud_cnt == BPS_LAST);

    // Select the frame byte for the current byte index from the shadowed payload
    always_comb begin
        cur_byte = HEADER;
        case (byte_cnt)
            3'd0: cur_byte = HEADER;
            3'd1: cur_byte = shadow_a;
            3'd2: cur_byte = shadow_b[15:8];
            3'd3: cur_byte = shadow_b[7:0];
            3'd4: cur_byte = shadow_c[15:8];
            3'd5: cur_byte = shadow_c[7:0];
            3'd6: cur_byte = 8'h0D;
            3'd7: cur_byte = 8'h0A;
            default: cur_byte = HEADER;
        endcase
    end

    // Frame FSM: every bit is held for BPS_CNT cycles, the next line level is registered on terminal count
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            byte_cnt  <= '0;
            shadow_a  <= '0;
            shadow_b  <= '0;
            shadow_c  <= '0;
            pack_busy <= 1'b0;
            pack_done <= 1'b0;
            uart_txd  <= 1'b1;
        end else begin
            pack_done <= 1'b0;
            case (state)
                IDLE: begin
                    uart_txd <= 1'b1;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (pack_start) begin
                        shadow_a  <= dataA;
                        shadow_b  <= dataB;
                        shadow_c  <= dataC;
                        pack_busy <= 1'b1;
                        byte_cnt  <= '0;
                        uart_txd  <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        uart_txd <= cur_byte[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            uart_txd <= 1'b1;
                            state    <= STOP;
                        end else begin
                            bit_idx  <= bit_idx + 3'd1;
                            uart_txd <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (byte_cnt == 3'd7) begin
                            // last stop bit done: release the line and flag completion
                            pack_busy <= 1'b0;
                            pack_done <= 1'b1;
                            byte_cnt  <= '0;
                            uart_txd  <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            // next byte's start bit follows immediately, no idle gap
                            byte_cnt <= byte_cnt + 3'd1;
                            uart_txd <= 1'b0;
                            state    <= START;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
